// File: rtl/seq_shift_add_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier_pkg
//   Shared definitions for the sequential shift-and-add multiplier:
//   FSM state encoding and an elaboration-time clog2 used to size the
//   iteration counter.
// ---------------------------------------------------------------------------
package seq_shift_add_multiplier_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Number of bits needed to hold values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_addern.sv
// ---------------------------------------------------------------------------
// addern
//   Parameterised N-bit ripple-carry adder.
//   Ports:
//     a, b  : N-bit addends
//     cin   : carry in
//     sum   : N-bit sum
//     cout  : carry out of the most significant bit
// ---------------------------------------------------------------------------
module addern #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic carry;
        // NOTE: every output of a combinational block gets a value before any
        // conditional logic, so no path can leave it unassigned and infer a latch.
        sum   = '0;
        carry = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//   Unsigned N x N -> 2N-bit multiplier, one shift-and-add step per clock,
//   reusing a single addern instance.
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : asynchronous active-low reset
//     start   : request, accepted when busy=0 (IDLE or DONE)
//     a, b    : multiplicand / multiplier, captured on acceptance
//     busy    : high during the N iteration cycles
//     done    : one-cycle pulse, product valid
//     product : registered 2N-bit result, held until the next DONE
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = clog2(N + 1);

    state_t          state;
    state_t          next_state;
    logic [N-1:0]    mcand;
    logic [N-1:0]    acc;
    logic [N-1:0]    mq;
    logic [CW-1:0]   count;

    logic            load;
    logic            step;
    logic            last;

    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            cout;
    logic [2*N-1:0]  shifted;

    // Partial product only when the current multiplier LSB is set.
    assign addend = mq[0] ? mcand : '0;

    addern #(.N(N)) u_addern (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Right shift of {cout,sum,mq} by one; cout must survive into acc's MSB.
    assign shifted = {cout, sum, mq[N-1:1]};
    assign last    = (count == CW'(1));

    // NOTE: every register, including the datapath and the product copy, is
    // cleared by reset so nothing downstream ever sees X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // Back-to-back acceptance straight out of DONE.
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            count <= CW'(N);
        end else if (step) begin
            {acc, mq} <= shifted;
            count     <= count - CW'(1);
            // product is only refreshed on entry to DONE, so it holds the
            // previous result while a new operation iterates.
            if (last) begin
                product <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//   Self-checking bench for seq_shift_add_multiplier (N=32). Expected products
//   come from plain 64-bit multiplication; timing expectations come from the
//   accept-to-done latency of N+1 cycles.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

    localparam int N = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int             n_checks;
    int             n_fail;
    logic [2*N-1:0] prev_product;

    seq_shift_add_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [63:0] wx;
        logic [63:0] wy;
        wx = 64'(x);
        wy = 64'(y);
        return wx * wy;
    endfunction

    // Called at a negedge: presents one request for the next rising edge.
    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y);
        prev_product = product;
        start = 1'b1;
        a     = x;
        b     = y;
    endtask

    // Waits for done, scrambling a/b after acceptance. Optionally re-asserts
    // start with 9x9 on busy cycle 'poke'. Returns at the done negedge.
    task automatic wait_done(input string tag, input logic [63:0] exp, input int poke);
        int lat;
        int busy_n;
        bit held;
        bit seen;
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        seen   = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (poke != 0 && lat == poke) begin
                start = 1'b1;
                a     = 9;
                b     = 9;
            end
            if (poke != 0 && lat == poke + 1) begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else if (product !== prev_product) held = 1'b0;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"},   64'(lat),  64'(N + 1));
        check({tag, "_busy_cyc"},  64'(busy_n), 64'(N));
        check({tag, "_held"},      64'(held), 64'd1);
        check({tag, "_product"},   product,   exp);
    endtask

    // One cycle after done with no new request: pulse ended, result held.
    task automatic finish_idle(input string tag, input logic [63:0] exp);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"},  64'(busy), 64'd0);
        check({tag, "_hold"},       product,   exp);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [63:0] exp;
        exp = model_mul(x, y);
        start_op(x, y);
        wait_done(tag, exp, 0);
        finish_idle(tag, exp);
    endtask

    initial begin
        int dones;
        logic [N-1:0] rx;
        logic [N-1:0] ry;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        prev_product = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_done",    64'(done), 64'd0);
        check("rst_product", product,   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op("basic",  32'd3,          32'd5);
        check("basic_value", product, 64'd15);
        run_op("ones",   32'hFFFF_FFFF,  32'hFFFF_FFFF);
        check("ones_value", product, 64'hFFFF_FFFE_0000_0001);
        run_op("msb",    32'h8000_0000,  32'd2);
        check("msb_value", product, 64'h1_0000_0000);
        run_op("zero",   32'd0,          32'hDEAD_BEEF);
        run_op("ident",  32'd1,          32'hDEAD_BEEF);
        check("ident_value", product, 64'h0000_0000_DEAD_BEEF);

        // start during busy is ignored.
        start_op(32'd6, 32'd7);
        wait_done("busy_start", 64'd42, 10);
        finish_idle("busy_start", 64'd42);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("busy_start_extra_done", 64'(dones), 64'd0);

        // Back-to-back: new request in the done cycle.
        start_op(32'd4, 32'd4);
        wait_done("b2b_first", 64'd16, 0);
        start_op(32'd2, 32'd3);
        wait_done("b2b_second", 64'd6, 0);
        finish_idle("b2b_second", 64'd6);

        // Reset in the middle of RUN.
        start_op(32'd5, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    64'(busy), 64'd0);
        check("mid_rst_done",    64'(done), 64'd0);
        check("mid_rst_product", product,   64'd0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_rst_no_done", 64'(dones), 64'd0);
        check("mid_rst_idle_product", product, 64'd0);
        run_op("after_rst", 32'd10, 32'd10);
        check("after_rst_value", product, 64'd100);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i % 5 == 0) rx = rx | 32'hF000_0000;
            run_op("rand", rx, ry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
